// File: rtl/test_host.sv
// test_host: responder for the riscv-tests tohost/fromhost exit protocol.
//
// Sits on the core's data-memory bus. Stores to the tohost word are decoded into a
// sticky pass / fail verdict; if no verdict arrives within TIMEOUT cycles the verdict
// becomes timeout. The bench reads the verdict outputs directly.
//
// Ports:
//   clk            - clock, rising edge active
//   rst            - asynchronous active-low reset
//   req_valid      - bus request present
//   req_ready      - device can accept (registered, high from first edge after reset)
//   req_we         - 1 = write, 0 = read
//   req_addr       - byte address, bits [1:0] ignored
//   req_wdata      - write data
//   resp_valid     - one-cycle response pulse, one cycle after acceptance
//   resp_rdata     - read data, valid with resp_valid (0 for write responses)
//   done           - a verdict has been reached
//   pass           - verdict is pass
//   timeout        - verdict is timeout
//   fail_testnum   - tohost[31:1] while the verdict is fail, else 0
//   cycles         - cycles spent in the run state

module test_host #(
    parameter logic [31:0] TOHOST_ADDR   = 32'h0000_1000,
    parameter logic [31:0] FROMHOST_ADDR = 32'h0000_1040,
    parameter logic [31:0] TIMEOUT       = 32'd5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [30:0] fail_testnum,
    output logic [31:0] cycles
);

    typedef enum logic [1:0] {
        StRun,
        StPass,
        StFail,
        StTimeout
    } state_e;

    state_e      state_q, state_d;
    logic        req_ready_q;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [31:0] tohost_q, tohost_d;
    logic [31:0] fromhost_q, fromhost_d;
    logic [31:0] cycles_q, cycles_d;

    logic accept;
    logic hit_tohost;
    logic hit_fromhost;
    logic wr_tohost;
    logic wr_fromhost;
    logic terminal_wr;
    logic unused_addr_lsbs;

    // Byte offset within the word plays no part in decode.
    assign unused_addr_lsbs = ^req_addr[1:0];

    assign accept       = req_valid && req_ready_q;
    assign hit_tohost   = (req_addr[31:2] == TOHOST_ADDR[31:2]);
    assign hit_fromhost = (req_addr[31:2] == FROMHOST_ADDR[31:2]);
    assign wr_tohost    = accept && req_we && hit_tohost;
    assign wr_fromhost  = accept && req_we && hit_fromhost;
    // Odd tohost values end the run; even values (0, syscall) are only latched.
    assign terminal_wr  = wr_tohost && req_wdata[0];

    // Register file and response path.
    always_comb begin
        tohost_d     = tohost_q;
        fromhost_d   = fromhost_q;
        resp_valid_d = accept;
        resp_rdata_d = 32'h0;

        if (wr_tohost) begin
            tohost_d = req_wdata;
        end
        if (wr_fromhost) begin
            fromhost_d = req_wdata;
        end

        // Reads see the register contents from before this edge's write.
        if (accept && !req_we) begin
            if (hit_tohost) begin
                resp_rdata_d = tohost_q;
            end else if (hit_fromhost) begin
                resp_rdata_d = fromhost_q;
            end else begin
                resp_rdata_d = 32'h0;
            end
        end
    end

    // Verdict FSM: only RUN has exits; all verdict states are sticky until reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                // A terminal write on the timeout edge takes priority over the timeout.
                if (terminal_wr) begin
                    state_d = (req_wdata == 32'd1) ? StPass : StFail;
                end else if (cycles_q == TIMEOUT - 32'd1) begin
                    state_d = StTimeout;
                end
            end
            StPass:    state_d = StPass;
            StFail:    state_d = StFail;
            StTimeout: state_d = StTimeout;
            default:   state_d = StRun;
        endcase
    end

    // Cycle counter counts every edge spent in RUN, including the leaving edge.
    always_comb begin
        cycles_d = cycles_q;
        if (state_q == StRun && cycles_q != 32'hFFFF_FFFF) begin
            cycles_d = cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StRun;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            tohost_q     <= 32'h0;
            fromhost_q   <= 32'h0;
            cycles_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= 1'b1;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            tohost_q     <= tohost_d;
            fromhost_q   <= fromhost_d;
            cycles_q     <= cycles_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign done         = (state_q != StRun);
    assign pass         = (state_q == StPass);
    assign timeout      = (state_q == StTimeout);
    assign fail_testnum = (state_q == StFail) ? tohost_q[31:1] : 31'h0;
    assign cycles       = cycles_q;

endmodule

// File: tb/tb_test_host.sv
// Self-checking bench for test_host. Main instance uses TIMEOUT=50; a second
// instance with TIMEOUT=10 covers the write-on-timeout-edge race.
// Read responses are checked through a scoreboard queue filled at request time.

module tb_test_host;

    localparam logic [31:0] ToHost   = 32'h0000_1000;
    localparam logic [31:0] FromHost = 32'h0000_1040;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [30:0] fail_testnum;
    logic [31:0] cycles;

    logic        req_valid_s;
    logic        req_ready_s;
    logic        req_we_s;
    logic [31:0] req_addr_s;
    logic [31:0] req_wdata_s;
    logic        resp_valid_s;
    logic [31:0] resp_rdata_s;
    logic        done_s;
    logic        pass_s;
    logic        timeout_s;
    logic [30:0] fail_testnum_s;
    logic [31:0] cycles_s;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rd;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] tohost_m;
    logic [31:0] fromhost_m;

    test_host #(
        .TOHOST_ADDR  (ToHost),
        .FROMHOST_ADDR(FromHost),
        .TIMEOUT      (32'd50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .fail_testnum(fail_testnum),
        .cycles      (cycles)
    );

    test_host #(
        .TOHOST_ADDR  (ToHost),
        .FROMHOST_ADDR(FromHost),
        .TIMEOUT      (32'd10)
    ) dut_s (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid_s),
        .req_ready   (req_ready_s),
        .req_we      (req_we_s),
        .req_addr    (req_addr_s),
        .req_wdata   (req_wdata_s),
        .resp_valid  (resp_valid_s),
        .resp_rdata  (resp_rdata_s),
        .done        (done_s),
        .pass        (pass_s),
        .timeout     (timeout_s),
        .fail_testnum(fail_testnum_s),
        .cycles      (cycles_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Response monitor: every resp_valid pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst && resp_valid) begin
            if (sb_q.size() == 0) begin
                check("resp_unexpected", {31'b0, resp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.rd) begin
                    check("resp_rdata", resp_rdata, e.data);
                end
            end
        end
    end

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Drive a request at a negedge; returns at the following negedge with resp checked.
    task automatic bus_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        logic [29:0] w;
        w      = addr[31:2];
        e.rd   = !we;
        e.data = 32'h0;
        if (!we) begin
            if (w == ToHost[31:2])        e.data = tohost_m;
            else if (w == FromHost[31:2]) e.data = fromhost_m;
        end else begin
            if (w == ToHost[31:2])        tohost_m   = wdata;
            else if (w == FromHost[31:2]) fromhost_m = wdata;
        end
        sb_q.push_back(e);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        check("resp_valid", {31'b0, resp_valid}, 32'd1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_ready"},   {31'b0, req_ready},    32'd0);
        check({tag, "_rvalid"},  {31'b0, resp_valid},   32'd0);
        check({tag, "_rdata"},   resp_rdata,            32'd0);
        check({tag, "_done"},    {31'b0, done},         32'd0);
        check({tag, "_pass"},    {31'b0, pass},         32'd0);
        check({tag, "_timeout"}, {31'b0, timeout},      32'd0);
        check({tag, "_failnum"}, {1'b0, fail_testnum},  32'd0);
        check({tag, "_cycles"},  cycles,                32'd0);
    endtask

    // Reset pulse mid-cycle; returns at the negedge where rst is released.
    task automatic do_reset();
        req_valid   = 1'b0;
        req_valid_s = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_cleared("rst");
        sb_q.delete();
        tohost_m   = 32'h0;
        fromhost_m = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        check("rel_ready", {31'b0, req_ready}, 32'd0);
    endtask

    initial begin
        bit seen;
        rst         = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        req_valid_s = 1'b0;
        req_we_s    = 1'b0;
        req_addr_s  = 32'h0;
        req_wdata_s = 32'h0;
        tohost_m    = 32'h0;
        fromhost_m  = 32'h0;

        #2 check_cleared("init");

        // Register access
        do_reset();
        idle(1);
        check("ready_up", {31'b0, req_ready}, 32'd1);
        check("cyc_first", cycles, 32'd1);
        bus_req(1'b1, FromHost, 32'hDEAD_BEEF);
        bus_req(1'b0, FromHost, 32'h0);
        bus_req(1'b0, 32'h0000_2000, 32'h0);
        bus_req(1'b0, FromHost | 32'h3, 32'h0);
        bus_req(1'b1, ToHost, 32'h2);
        check("even_done", {31'b0, done}, 32'd0);
        bus_req(1'b0, ToHost, 32'h0);
        bus_req(1'b1, 32'h0000_3000, 32'h5);
        check("other_done", {31'b0, done}, 32'd0);
        bus_req(1'b1, ToHost, 32'h0);
        bus_req(1'b0, ToHost, 32'h0);
        idle(1);

        // Pass at cycle 20
        do_reset();
        idle(20);
        check("pre_cycles", cycles, 32'd20);
        check("pre_done", {31'b0, done}, 32'd0);
        bus_req(1'b1, ToHost, 32'h1);
        check("pass_done", {31'b0, done}, 32'd1);
        check("pass_pass", {31'b0, pass}, 32'd1);
        check("pass_fnum", {1'b0, fail_testnum}, 32'd0);
        check("pass_cycles", cycles, 32'd21);
        idle(3);
        check("pass_frozen", cycles, 32'd21);
        check("pass_sticky", {31'b0, pass}, 32'd1);

        // Fail, stickiness, then reset with a response pending
        do_reset();
        idle(2);
        bus_req(1'b1, ToHost, 32'h7);
        check("fail_done", {31'b0, done}, 32'd1);
        check("fail_pass", {31'b0, pass}, 32'd0);
        check("fail_fnum", {1'b0, fail_testnum}, 32'd3);
        bus_req(1'b1, ToHost, 32'h1);
        check("fail_sticky", {31'b0, pass}, 32'd0);
        bus_req(1'b0, ToHost, 32'h0);
        check("fail_fnum2", {1'b0, fail_testnum}, 32'd0);
        idle(2);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = ToHost;
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_cleared("midrst");
        sb_q.delete();
        tohost_m   = 32'h0;
        fromhost_m = 32'h0;
        req_valid  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("mid_ready0", {31'b0, req_ready}, 32'd0);
        idle(1);
        check("mid_ready1", {31'b0, req_ready}, 32'd1);
        check("mid_cycles", cycles, 32'd1);
        bus_req(1'b0, ToHost, 32'h0);

        // Timeout with TIMEOUT=50
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            idle(1);
            if (done) seen = 1'b1;
        end
        check("to_seen", {31'b0, seen}, 32'd1);
        check("to_timeout", {31'b0, timeout}, 32'd1);
        check("to_cycles", cycles, 32'd50);
        check("to_pass", {31'b0, pass}, 32'd0);
        check("to_s_timeout", {31'b0, timeout_s}, 32'd1);
        check("to_s_cycles", cycles_s, 32'd10);
        bus_req(1'b1, ToHost, 32'h1);
        check("to_late_pass", {31'b0, pass}, 32'd0);
        check("to_late_to", {31'b0, timeout}, 32'd1);
        check("to_frozen", cycles, 32'd50);

        // Terminal write on the timeout edge (TIMEOUT=10 instance)
        do_reset();
        idle(9);
        check("sim_cycles", cycles_s, 32'd9);
        check("sim_pre_done", {31'b0, done_s}, 32'd0);
        req_valid_s = 1'b1;
        req_we_s    = 1'b1;
        req_addr_s  = ToHost;
        req_wdata_s = 32'h1;
        @(posedge clk);
        @(negedge clk);
        req_valid_s = 1'b0;
        check("sim_resp", {31'b0, resp_valid_s}, 32'd1);
        check("sim_pass", {31'b0, pass_s}, 32'd1);
        check("sim_timeout", {31'b0, timeout_s}, 32'd0);
        check("sim_cycles10", cycles_s, 32'd10);

        idle(2);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
